iguana_gpio_ctrl: RTL and testbench
===================================

Name: iguana_gpio_ctrl

Overview:
Parametrised GPIO controller that replaces the fixed 8-pin GPIO truncation and output-enable inversion at the chip top. It provides:
- a configurable pin count;
- input synchronisation and per-pin debouncing;
- rising and falling edge interrupts;
- a register-bus slave with single-cycle response.

It sits between the SoC external register demux and the GPIO pads, and drives pad-polarity (active-low) output enables directly.

Parameters:
NumGpio, 8, number of GPIO pins (1..32); register bits [31:NumGpio] read 0 and ignore writes
SyncStages, 2, flip-flop synchroniser depth on gpio_i (>=2)
CntWidth, 16, debounce counter width; DEBOUNCE register uses bits [CntWidth-1:0]
RegAddrWidth, 5, register-bus byte address width

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset
reg_valid_i  in  1  register request valid
reg_write_i  in  1  1=write, 0=read
reg_addr_i  in  RegAddrWidth  byte address; bits [1:0] ignored
reg_wdata_i  in  32  write data
reg_wstrb_i  in  4  byte strobes
reg_rdata_o  out  32  read data, valid while reg_ready_o
reg_ready_o  out  1  request accepted
reg_error_o  out  1  unmapped address or write to a read-only register
gpio_i  in  NumGpio  pad inputs (asynchronous)
gpio_o  out  NumGpio  pad output values
gpio_en_no  out  NumGpio  pad output enables, active low
irq_o  out  1  level interrupt

Interface decision: one clock, clk_i; reset rst_ni is asynchronous and active-low.

Behaviour:
- Register map (byte offsets):
  - 0x00 DATA_OUT (RW)
  - 0x04 OE (RW, 1=drive)
  - 0x08 DATA_IN (RO, debounced value)
  - 0x0C IRQ_RISE_EN (RW)
  - 0x10 IRQ_FALL_EN (RW)
  - 0x14 IRQ_STATUS (RW1C)
  - 0x18 DEBOUNCE (RW)
  - Other offsets: reg_error_o=1, read data 0.
- Register-bus handshake:
  - reg_ready_o = reg_valid_i, combinational.
  - rdata and error are combinational from the current state; writes take effect at the clock edge.
  - Byte strobes apply per byte.
  - A write to DATA_IN sets error and has no effect.
- Reset values: all registers 0, synchroniser and stable state 0, counters 0. Therefore gpio_o=0, gpio_en_no=all-ones (tristated), irq_o=0, reg_rdata_o=0.
- Output path:
  - gpio_o = DATA_OUT[NumGpio-1:0] registered, i.e. visible 1 cycle after the write edge.
  - gpio_en_no = ~OE, same timing.
- Input path:
  - gpio_i passes through SyncStages flops to give sync[i].
  - Per pin: a stable[i] bit and a cnt[i] of CntWidth bits.
  - If DEBOUNCE==0: stable[i] <= sync[i] every cycle, cnt held 0.
  - Otherwise:
    - if sync[i]==stable[i], cnt[i]<=0;
    - else if cnt[i]==DEBOUNCE-1, then stable[i]<=sync[i] and cnt[i]<=0;
    - else cnt[i]++.
    - Effective filter: sync must differ for DEBOUNCE consecutive cycles.
    - A glitch shorter than that resets the counter and never changes stable.
  - A DEBOUNCE write mid-count takes effect on the next cycle. A counter already >= the new value-1 updates stable on that cycle; the comparison is >= DEBOUNCE-1.
- Edges:
  - rise[i] = stable_next & ~stable.
  - fall[i] = ~stable_next & stable.
  - Both are evaluated on the cycle stable changes.
- IRQ_STATUS[i] set when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - A W1C write clears the written 1-bits.
  - A set and a clear of the same bit in the same cycle: set wins.
- irq_o = |(IRQ_STATUS), registered as a direct flop OR (combinational from the status flops).
- Latency (DEBOUNCE=0): pad edge to DATA_IN change = SyncStages+1 cycles; to irq_o high = SyncStages+1 cycles.
- Enabling IRQ_*_EN does not retro-trigger on current pin levels; only edges after enable set status.
- Pins configured as outputs still sample gpio_i; loopback is permitted.
- Asynchronous reset mid-debounce clears counters and stable. A pin held high through reset produces a rising edge after release, setting status only if enabled; enables are 0 after reset, so no status is set.

Test Plan:
- Reset: assert rst_ni=0 mid-traffic -> gpio_en_no=8'hFF, gpio_o=0, irq_o=0 immediately (asynchronous); all register reads return 0.
- Output: write OE=0x0F then DATA_OUT=0xA5 -> next cycle gpio_en_no=0xF0, gpio_o=0xA5; read back 0xA5 and 0x0F; reg_ready_o same cycle as reg_valid_i.
- Sync and edge IRQ, DEBOUNCE=0: RISE_EN=0x01, drive gpio_i[0] 0->1 -> DATA_IN[0]=1 and irq_o=1 after 3 cycles; IRQ_STATUS=0x01; W1C write 0x01 -> irq_o=0 next cycle.
- Debounce, DEBOUNCE=4, FALL_EN=0x02 with pin1 high:
  - 3-cycle low glitch on gpio_i[1] -> DATA_IN[1] stays 1, no IRQ.
  - 4-cycle low -> DATA_IN[1]=0 and IRQ_STATUS[1]=1.
- Simultaneous events: a rising edge on pin 2 in the same cycle as a W1C of bit 2 -> IRQ_STATUS[2] remains 1.
- Errors and masking, NumGpio=8:
  - read 0x1C -> reg_error_o=1, rdata=0;
  - write DATA_IN -> error=1, no state change;
  - write DATA_OUT=0xFFFF_FFFF -> read returns 0x0000_00FF;
  - wstrb=4'b0001 write of 0x12345678 over 0 -> reads 0x78.

Source files
------------

// File: rtl/iguana_gpio_ctrl.sv
// rtl/iguana_gpio_ctrl.sv - parametrised GPIO controller: synchronised, debounced inputs, edge IRQs, register slave
module iguana_gpio_ctrl #(
    parameter int NumGpio      = 8,
    parameter int SyncStages   = 2,
    parameter int CntWidth     = 16,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    reg_valid_i,
    input  logic                    reg_write_i,
    input  logic [RegAddrWidth-1:0] reg_addr_i,
    input  logic [31:0]             reg_wdata_i,
    input  logic [3:0]              reg_wstrb_i,
    output logic [31:0]             reg_rdata_o,
    output logic                    reg_ready_o,
    output logic                    reg_error_o,
    input  logic [NumGpio-1:0]      gpio_i,
    output logic [NumGpio-1:0]      gpio_o,
    output logic [NumGpio-1:0]      gpio_en_no,
    output logic                    irq_o
);

    localparam logic [RegAddrWidth-1:0] AddrDataOut  = RegAddrWidth'('h00);
    localparam logic [RegAddrWidth-1:0] AddrOe       = RegAddrWidth'('h04);
    localparam logic [RegAddrWidth-1:0] AddrDataIn   = RegAddrWidth'('h08);
    localparam logic [RegAddrWidth-1:0] AddrRiseEn   = RegAddrWidth'('h0C);
    localparam logic [RegAddrWidth-1:0] AddrFallEn   = RegAddrWidth'('h10);
    localparam logic [RegAddrWidth-1:0] AddrStatus   = RegAddrWidth'('h14);
    localparam logic [RegAddrWidth-1:0] AddrDebounce = RegAddrWidth'('h18);

    logic [NumGpio-1:0]  data_out_q, oe_q, rise_en_q, fall_en_q;
    logic [NumGpio-1:0]  irq_status_q, irq_status_d, irq_set, irq_clr;
    logic [CntWidth-1:0] debounce_q;
    logic [NumGpio-1:0]  gpio_o_q, gpio_en_nq;
    logic [NumGpio-1:0]  sync_q [SyncStages];
    logic [NumGpio-1:0]  sync;
    logic [NumGpio-1:0]  stable_q, stable_d, rise, fall;
    logic [CntWidth-1:0] cnt_q [NumGpio];
    logic [CntWidth-1:0] cnt_d [NumGpio];

    logic [RegAddrWidth-1:0] addr;
    logic [31:0]             wmask, wdata_m, rdata;
    logic [NumGpio-1:0]      pin_wmask, pin_wdata;
    logic                    wr, mapped, read_only;
    logic                    we_dout, we_oe, we_rise, we_fall, we_status, we_deb;
    logic                    unused_bits;

    assign addr      = {reg_addr_i[RegAddrWidth-1:2], 2'b00};
    assign wmask     = {{8{reg_wstrb_i[3]}}, {8{reg_wstrb_i[2]}}, {8{reg_wstrb_i[1]}}, {8{reg_wstrb_i[0]}}};
    assign wdata_m   = reg_wdata_i & wmask;
    assign pin_wmask = wmask[NumGpio-1:0];
    assign pin_wdata = wdata_m[NumGpio-1:0];
    assign wr        = reg_valid_i & reg_write_i;

    assign unused_bits = ^{reg_addr_i[1:0], wmask, wdata_m};

    always_comb begin
        rdata     = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (addr)
            AddrDataOut:  rdata = 32'(data_out_q);
            AddrOe:       rdata = 32'(oe_q);
            AddrDataIn: begin
                rdata     = 32'(stable_q);
                read_only = 1'b1;
            end
            AddrRiseEn:   rdata = 32'(rise_en_q);
            AddrFallEn:   rdata = 32'(fall_en_q);
            AddrStatus:   rdata = 32'(irq_status_q);
            AddrDebounce: rdata = 32'(debounce_q);
            default:      mapped = 1'b0;
        endcase
    end

    assign reg_ready_o = reg_valid_i;
    assign reg_rdata_o = rdata;
    assign reg_error_o = reg_valid_i & (~mapped | (reg_write_i & read_only));

    assign we_dout   = wr & (addr == AddrDataOut);
    assign we_oe     = wr & (addr == AddrOe);
    assign we_rise   = wr & (addr == AddrRiseEn);
    assign we_fall   = wr & (addr == AddrFallEn);
    assign we_status = wr & (addr == AddrStatus);
    assign we_deb    = wr & (addr == AddrDebounce);

    assign sync = sync_q[SyncStages-1];

    // The >= compare lets a shortened DEBOUNCE value release an in-flight count at once.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NumGpio; i++) begin
            if (debounce_q == '0) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= debounce_q - CntWidth'(1)) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
        end
    end

    assign rise         = stable_d & ~stable_q;
    assign fall         = ~stable_d & stable_q;
    assign irq_set      = (rise & rise_en_q) | (fall & fall_en_q);
    assign irq_clr      = we_status ? pin_wdata : '0;
    // A new event overrides a simultaneous clear so no edge is lost.
    assign irq_status_d = (irq_status_q & ~irq_clr) | irq_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_out_q   <= '0;
            oe_q         <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            debounce_q   <= '0;
            gpio_o_q     <= '0;
            gpio_en_nq   <= '1;
            stable_q     <= '0;
            for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
            for (int i = 0; i < NumGpio; i++) cnt_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < NumGpio; i++) cnt_q[i] <= cnt_d[i];
            stable_q     <= stable_d;
            irq_status_q <= irq_status_d;
            gpio_o_q     <= data_out_q;
            gpio_en_nq   <= ~oe_q;
            if (we_dout) data_out_q <= (data_out_q & ~pin_wmask) | pin_wdata;
            if (we_oe)   oe_q       <= (oe_q & ~pin_wmask) | pin_wdata;
            if (we_rise) rise_en_q  <= (rise_en_q & ~pin_wmask) | pin_wdata;
            if (we_fall) fall_en_q  <= (fall_en_q & ~pin_wmask) | pin_wdata;
            if (we_deb)  debounce_q <= (debounce_q & ~wmask[CntWidth-1:0]) | wdata_m[CntWidth-1:0];
        end
    end

    assign gpio_o     = gpio_o_q;
    assign gpio_en_no = gpio_en_nq;
    assign irq_o      = |irq_status_q;

endmodule

// File: tb/tb_iguana_gpio_ctrl.sv
// tb/tb_iguana_gpio_ctrl.sv - self-checking bench for iguana_gpio_ctrl
module tb_iguana_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_valid = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [3:0]  reg_wstrb = '0;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic        reg_error;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_en_n;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    iguana_gpio_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reg_valid_i (reg_valid),
        .reg_write_i (reg_write),
        .reg_addr_i  (reg_addr),
        .reg_wdata_i (reg_wdata),
        .reg_wstrb_i (reg_wstrb),
        .reg_rdata_o (reg_rdata),
        .reg_ready_o (reg_ready),
        .reg_error_o (reg_error),
        .gpio_i      (gpio_in),
        .gpio_o      (gpio_out),
        .gpio_en_no  (gpio_en_n),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic e);
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d; reg_wstrb = s;
        #1;
        e = reg_error;
        @(posedge clk);
        #1;
        reg_valid = 1'b0; reg_write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic e);
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a;
        #1;
        d = reg_rdata;
        e = reg_error;
        reg_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (gpio_en_n !== 8'hFF) begin n_fail++; $display("FAIL reset_oe_n: got %h expected ff", gpio_en_n); end
        n_cmp++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL reset_gpio_o: got %h expected 00", gpio_out); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int w = 0; w < 7; w++) begin
            bus_read(5'(w * 4), d, e);
            n_cmp++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL reset_read_%0d: got %h err %b expected 0 err 0", w, d, e); end
        end
    endtask

    task automatic test_output();
        logic [31:0] d; logic e;
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 5'h00;
        #1;
        n_cmp++; if (reg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_high: got %b expected 1", reg_ready); end
        reg_valid = 1'b0;
        #1;
        n_cmp++; if (reg_ready !== 1'b0) begin n_fail++; $display("FAIL ready_low: got %b expected 0", reg_ready); end
        bus_write(5'h04, 32'h0F, 4'hF, e);
        bus_write(5'h00, 32'hA5, 4'hF, e);
        n_cmp++; if (gpio_en_n !== 8'hF0) begin n_fail++; $display("FAIL oe_n_timing: got %h expected f0", gpio_en_n); end
        n_cmp++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL gpio_o_early: got %h expected 00", gpio_out); end
        tick();
        n_cmp++; if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_o: got %h expected a5", gpio_out); end
        bus_read(5'h00, d, e);
        n_cmp++; if (d !== 32'hA5) begin n_fail++; $display("FAIL read_dout: got %h expected a5", d); end
        bus_read(5'h04, d, e);
        n_cmp++; if (d !== 32'h0F) begin n_fail++; $display("FAIL read_oe: got %h expected 0f", d); end
    endtask

    task automatic test_irq_sync();
        logic [31:0] d; logic e;
        bus_write(5'h0C, 32'h01, 4'hF, e);
        gpio_in[0] = 1'b1;
        repeat (2) tick();
        bus_read(5'h08, d, e);
        n_cmp++; if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL sync_early: got din %h irq %b expected 0 0", d, irq); end
        tick();
        bus_read(5'h08, d, e);
        n_cmp++; if (d !== 32'h1 || irq !== 1'b1) begin n_fail++; $display("FAIL sync_latency: got din %h irq %b expected 1 1", d, irq); end
        bus_read(5'h14, d, e);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_rise: got %h expected 1", d); end
        bus_write(5'h14, 32'h01, 4'hF, e);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b expected 0", irq); end
    endtask

    task automatic test_debounce();
        logic [31:0] d; logic e;
        bus_write(5'h18, 32'h4, 4'hF, e);
        bus_write(5'h10, 32'h2, 4'hF, e);
        gpio_in[1] = 1'b1;
        repeat (12) tick();
        bus_write(5'h14, 32'hFF, 4'hF, e);
        gpio_in[1] = 1'b0;
        repeat (3) tick();
        gpio_in[1] = 1'b1;
        repeat (10) tick();
        bus_read(5'h08, d, e);
        n_cmp++; if (d !== 32'h3) begin n_fail++; $display("FAIL glitch_din: got %h expected 3", d); end
        bus_read(5'h14, d, e);
        n_cmp++; if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq: got %h irq %b expected 0 0", d, irq); end
        gpio_in[1] = 1'b0;
        repeat (8) tick();
        bus_read(5'h08, d, e);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL debounced_din: got %h expected 1", d); end
        bus_read(5'h14, d, e);
        n_cmp++; if (d !== 32'h2 || irq !== 1'b1) begin n_fail++; $display("FAIL debounced_fall: got %h irq %b expected 2 1", d, irq); end
        bus_write(5'h14, 32'h2, 4'hF, e);
    endtask

    task automatic test_simultaneous();
        logic [31:0] d; logic e;
        bus_write(5'h18, 32'h0, 4'hF, e);
        bus_write(5'h0C, 32'h4, 4'hF, e);
        bus_write(5'h14, 32'hFF, 4'hF, e);
        gpio_in[2] = 1'b1;
        repeat (2) tick();
        bus_write(5'h14, 32'h4, 4'hF, e);
        bus_read(5'h14, d, e);
        n_cmp++; if (d !== 32'h4) begin n_fail++; $display("FAIL set_wins: got %h expected 4", d); end
        bus_read(5'h08, d, e);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL simul_din: got %h expected 5", d); end
        bus_write(5'h14, 32'h4, 4'hF, e);
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e;
        bus_read(5'h1C, d, e);
        n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL unmapped: got %h err %b expected 0 err 1", d, e); end
        bus_write(5'h08, 32'hFF, 4'hF, e);
        n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL ro_write_err: got %b expected 1", e); end
        bus_read(5'h08, d, e);
        n_cmp++; if (d !== 32'h5 || e !== 1'b0) begin n_fail++; $display("FAIL ro_unchanged: got %h err %b expected 5 err 0", d, e); end
        bus_write(5'h00, 32'hFFFF_FFFF, 4'hF, e);
        n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL rw_write_err: got %b expected 0", e); end
        bus_read(5'h00, d, e);
        n_cmp++; if (d !== 32'hFF) begin n_fail++; $display("FAIL mask_upper: got %h expected ff", d); end
        bus_write(5'h00, 32'h0, 4'hF, e);
        bus_write(5'h00, 32'h1234_5678, 4'b0001, e);
        bus_read(5'h00, d, e);
        n_cmp++; if (d !== 32'h78) begin n_fail++; $display("FAIL strobe_dout: got %h expected 78", d); end
        bus_write(5'h18, 32'h1234_5678, 4'b0010, e);
        bus_read(5'h18, d, e);
        n_cmp++; if (d !== 32'h5600) begin n_fail++; $display("FAIL strobe_deb: got %h expected 5600", d); end
        bus_write(5'h18, 32'h0, 4'hF, e);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s, input logic [31:0] keep);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return ((old & ~m) | (d & m)) & keep;
    endfunction

    task automatic test_random_regs();
        logic [31:0] d, exp_d, wd; logic e, exp_e, wr;
        logic [3:0] s;
        int w;
        logic [31:0] m_dout, m_oe, m_rise, m_fall, m_deb, m_stat;
        m_dout = $urandom & 32'hFF; m_oe = $urandom & 32'hFF;
        m_rise = $urandom & 32'hFF; m_fall = $urandom & 32'hFF; m_deb = $urandom & 32'hFFFF;
        bus_write(5'h00, m_dout, 4'hF, e);
        bus_write(5'h04, m_oe, 4'hF, e);
        bus_write(5'h0C, m_rise, 4'hF, e);
        bus_write(5'h10, m_fall, 4'hF, e);
        bus_write(5'h18, m_deb, 4'hF, e);
        bus_write(5'h14, 32'hFFFF_FFFF, 4'hF, e);
        m_stat = 0;
        for (int it = 0; it < 60; it++) begin
            w  = $urandom_range(0, 7);
            wr = 1'($urandom);
            wd = $urandom;
            s  = 4'($urandom);
            exp_e = (w == 7) || (wr && w == 2);
            if (wr) begin
                bus_write(5'(w * 4), wd, s, e);
                case (w)
                    0: m_dout = merge(m_dout, wd, s, 32'hFF);
                    1: m_oe   = merge(m_oe, wd, s, 32'hFF);
                    3: m_rise = merge(m_rise, wd, s, 32'hFF);
                    4: m_fall = merge(m_fall, wd, s, 32'hFF);
                    5: m_stat = m_stat & ~merge(32'h0, wd, s, 32'hFF);
                    6: m_deb  = merge(m_deb, wd, s, 32'hFFFF);
                    default: ;
                endcase
                n_cmp++; if (e !== exp_e) begin n_fail++; $display("FAIL rnd_werr w%0d: got %b expected %b", w, e, exp_e); end
            end else begin
                bus_read(5'(w * 4), d, e);
                case (w)
                    0: exp_d = m_dout;
                    1: exp_d = m_oe;
                    2: exp_d = 32'h5;
                    3: exp_d = m_rise;
                    4: exp_d = m_fall;
                    5: exp_d = m_stat;
                    6: exp_d = m_deb;
                    default: exp_d = 0;
                endcase
                n_cmp++; if (d !== exp_d || e !== exp_e) begin n_fail++; $display("FAIL rnd_read w%0d: got %h err %b expected %h err %b", w, d, e, exp_d, exp_e); end
            end
            tick();
            n_cmp++; if (gpio_out !== m_dout[7:0] || gpio_en_n !== ~m_oe[7:0]) begin
                n_fail++; $display("FAIL rnd_pads: got o %h en_n %h expected %h %h", gpio_out, gpio_en_n, m_dout[7:0], ~m_oe[7:0]);
            end
        end
    endtask

    task automatic test_random_pins();
        logic [31:0] d; logic e;
        logic [7:0] rise_en, fall_en, p0, p1, p2, old_s, new_s, clr, stat, pad;
        rise_en = 8'($urandom); fall_en = 8'($urandom);
        bus_write(5'h18, 32'h0, 4'hF, e);
        bus_write(5'h0C, 32'(rise_en), 4'hF, e);
        bus_write(5'h10, 32'(fall_en), 4'hF, e);
        pad = 8'($urandom);
        gpio_in = pad;
        repeat (5) tick();
        bus_write(5'h14, 32'hFF, 4'hF, e);
        stat = 0; p0 = pad; p1 = pad; p2 = pad;
        for (int it = 0; it < 150; it++) begin
            pad = 8'($urandom);
            gpio_in = pad;
            clr = 0;
            if ($urandom_range(0, 3) == 0) begin
                clr = 8'($urandom);
                bus_write(5'h14, 32'(clr), 4'b0001, e);
            end else begin
                tick();
            end
            // DATA_IN follows the pad level sampled two edges before the current one.
            old_s = p2;
            p2 = p1; p1 = p0; p0 = pad;
            new_s = p2;
            stat = (stat & ~clr) | (new_s & ~old_s & rise_en) | (~new_s & old_s & fall_en);
            bus_read(5'h08, d, e);
            n_cmp++; if (d !== 32'(new_s)) begin n_fail++; $display("FAIL pin_din it%0d: got %h expected %h", it, d, new_s); end
            bus_read(5'h14, d, e);
            n_cmp++; if (d !== 32'(stat) || irq !== (|stat)) begin
                n_fail++; $display("FAIL pin_status it%0d: got %h irq %b expected %h irq %b", it, d, irq, stat, |stat);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e;
        bus_write(5'h04, 32'hFF, 4'hF, e);
        bus_write(5'h00, 32'h3C, 4'hF, e);
        bus_write(5'h0C, 32'hFF, 4'hF, e);
        gpio_in = 8'h00;
        repeat (4) tick();
        gpio_in = 8'hFF;
        repeat (4) tick();
        n_cmp++; if (irq !== 1'b1 || gpio_out !== 8'h3C || gpio_en_n !== 8'h00) begin
            n_fail++; $display("FAIL pre_reset: got irq %b o %h en_n %h expected 1 3c 00", irq, gpio_out, gpio_en_n);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (gpio_en_n !== 8'hFF || gpio_out !== 8'h00 || irq !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got en_n %h o %h irq %b expected ff 00 0", gpio_en_n, gpio_out, irq);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus_read(5'h08, d, e);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_din: got %h expected 0", d); end
        repeat (5) tick();
        bus_read(5'h08, d, e);
        n_cmp++; if (d !== 32'hFF) begin n_fail++; $display("FAIL held_pin_din: got %h expected ff", d); end
        bus_read(5'h14, d, e);
        n_cmp++; if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL held_pin_status: got %h irq %b expected 0 0", d, irq); end
    endtask

    initial begin
        test_reset();
        test_output();
        test_irq_sync();
        test_debounce();
        test_simultaneous();
        test_errors();
        test_random_regs();
        test_random_pins();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
